// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive monitor.
package uart_pkg;

    localparam int unsigned UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } uart_rx_state_t;

    // Clock cycles per serial bit (integer division).
    function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                                 input int unsigned baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO with level/full/empty status.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_full    = (r_count == (PTR_W+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_level   = r_count;
    // Head is forced to zero while empty so the output is defined out of reset.
    assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr];

    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage write port; contents need no reset because the head is gated by empty.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

endmodule

// File: rtl/uart_rx_monitor.sv
// 8N1 UART receiver feeding a small FWFT FIFO, with framing and overflow reporting.
module uart_rx_monitor
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rxd_i,
    output logic [UART_DATA_BITS-1:0]     data_o,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic [$clog2(FIFO_DEPTH):0]   level_o,
    output logic                          frame_err_o,
    output logic                          overflow_o,
    input  logic                          clear_i
);

    localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
    localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int unsigned IDX_W        = $clog2(UART_DATA_BITS);

    localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_RELOAD = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(UART_DATA_BITS - 1);

    // Synchroniser and FSM registers.
    logic                      r_sync1;
    logic                      r_sync2;
    uart_rx_state_t            r_state;
    logic [CNT_W-1:0]          r_cnt;
    logic [IDX_W-1:0]          r_bit_idx;
    logic [UART_DATA_BITS-1:0] r_shift;
    logic                      r_frame_err;
    logic                      r_overflow;

    // Next-state values.
    logic                      w_rxs;
    uart_rx_state_t            w_state_nxt;
    logic [CNT_W-1:0]          w_cnt_nxt;
    logic [IDX_W-1:0]          w_bit_idx_nxt;
    logic [UART_DATA_BITS-1:0] w_shift_nxt;
    logic                      w_push;
    logic                      w_frame_err_nxt;

    // FIFO interface.
    logic [UART_DATA_BITS-1:0] w_fifo_data;
    logic                      w_full;
    logic                      w_empty;
    logic [$clog2(FIFO_DEPTH):0] w_level;
    logic                      w_pop;

    assign w_rxs = r_sync2;
    assign w_pop = ~w_empty & ready_i;

    // Two-flop synchroniser for the asynchronous line; resets to the idle level.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rxd_i;
            r_sync2 <= r_sync1;
        end
    end

    // FSM state, bit timing and shift register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_bit_idx   <= w_bit_idx_nxt;
            r_shift     <= w_shift_nxt;
            r_frame_err <= w_frame_err_nxt;
        end
    end

    // Next-state logic: each state samples the line mid-bit when the counter hits zero.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_bit_idx_nxt   = r_bit_idx;
        w_shift_nxt     = r_shift;
        w_push          = 1'b0;
        w_frame_err_nxt = 1'b0;

        case (r_state)
            IDLE: begin
                if (!w_rxs) begin
                    w_state_nxt = START;
                    w_cnt_nxt   = HALF_RELOAD;
                end
            end
            START: begin
                if (r_cnt == '0) begin
                    if (w_rxs) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_state_nxt   = DATA;
                        w_cnt_nxt     = FULL_RELOAD;
                        w_bit_idx_nxt = '0;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            DATA: begin
                if (r_cnt == '0) begin
                    w_shift_nxt = {w_rxs, r_shift[UART_DATA_BITS-1:1]};
                    w_cnt_nxt   = FULL_RELOAD;
                    if (r_bit_idx == LAST_IDX) begin
                        w_state_nxt = STOP;
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + IDX_W'(1);
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            STOP: begin
                if (r_cnt == '0) begin
                    if (w_rxs) begin
                        w_push      = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_frame_err_nxt = 1'b1;
                        w_state_nxt     = BREAK;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            BREAK: begin
                if (w_rxs) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Sticky overflow flag; clear_i takes priority over a same-cycle drop.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (clear_i) begin
            r_overflow <= 1'b0;
        end else if (w_push && w_full && !w_pop) begin
            r_overflow <= 1'b1;
        end
    end

    sync_fifo #(
        .WIDTH (UART_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (r_shift),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (w_level)
    );

    assign data_o      = w_fifo_data;
    assign valid_o     = ~w_empty;
    assign level_o     = w_level;
    assign frame_err_o = r_frame_err;
    assign overflow_o  = r_overflow;

endmodule

// File: tb/tb_uart_rx_monitor.sv
// Directed bench for uart_rx_monitor at 10 clocks per bit, 8-entry FIFO.
module tb_uart_rx_monitor;
    import uart_pkg::*;

    localparam int unsigned CPB = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       rxd;
    logic [7:0] data_o;
    logic       valid_o;
    logic       ready_i;
    logic [3:0] level_o;
    logic       frame_err_o;
    logic       overflow_o;
    logic       clear_i;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned cyc      = 0;
    int unsigned start_cyc = 0;
    int unsigned rise_cyc  = 0;
    int unsigned fe_total  = 0;
    logic        prev_valid = 1'b0;
    logic [7:0]  popq [$];

    uart_rx_monitor #(
        .CLK_HZ     (1_000_000),
        .BAUD       (100_000),
        .FIFO_DEPTH (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rxd_i       (rxd),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .level_o     (level_o),
        .frame_err_o (frame_err_o),
        .overflow_o  (overflow_o),
        .clear_i     (clear_i)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Observers sample on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (frame_err_o) fe_total = fe_total + 1;
        if (valid_o && !prev_valid) rise_cyc = cyc;
        prev_valid = valid_o;
        if (valid_o && ready_i) popq.push_back(data_o);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (obs !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bit(input logic b);
        rxd = b;
        tick(CPB);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        start_cyc = cyc;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop);
    endtask

    task automatic pop_one();
        tick(1);
        ready_i = 1'b1;
        tick(1);
        ready_i = 1'b0;
    endtask

    int unsigned fe0;
    int          n0;

    initial begin
        rst = 1'b1; rxd = 1'b1; ready_i = 1'b0; clear_i = 1'b0;
        tick(3);
        rst = 1'b0;
        tick(2);
        @(negedge clk);
        check("rst_data",  32'(data_o),      32'h0);
        check("rst_valid", 32'(valid_o),     32'h0);
        check("rst_level", 32'(level_o),     32'h0);
        check("rst_ferr",  32'(frame_err_o), 32'h0);
        check("rst_ovf",   32'(overflow_o),  32'h0);

        // Single byte 0xA5, held in the FIFO.
        fe0 = fe_total;
        send_byte(8'hA5, 1'b1);
        tick(5);
        @(negedge clk);
        check("a5_valid",   32'(valid_o), 32'h1);
        check("a5_data",    32'(data_o),  32'hA5);
        check("a5_level",   32'(level_o), 32'h1);
        check("a5_ferr",    fe_total - fe0, 32'h0);
        check("a5_latency", rise_cyc - start_cyc, 32'd98);
        pop_one();
        @(negedge clk);
        check("a5_popped", 32'(valid_o), 32'h0);
        check("a5_lvl0",   32'(level_o), 32'h0);

        // Short low glitch is a false start.
        fe0 = fe_total;
        rxd = 1'b0;
        tick(3);
        rxd = 1'b1;
        tick(20);
        @(negedge clk);
        check("gl_level", 32'(level_o), 32'h0);
        check("gl_ferr",  fe_total - fe0, 32'h0);
        check("gl_idle",  32'(dut.r_state), 32'(IDLE));

        // Framing error followed by a held-low break, then a good frame.
        fe0 = fe_total;
        send_byte(8'h00, 1'b0);
        tick(30);
        rxd = 1'b1;
        tick(10);
        @(negedge clk);
        check("fe_pulses", fe_total - fe0, 32'h1);
        check("fe_level",  32'(level_o), 32'h0);
        check("fe_idle",   32'(dut.r_state), 32'(IDLE));
        send_byte(8'h5A, 1'b1);
        tick(5);
        @(negedge clk);
        check("fe_next_valid", 32'(valid_o), 32'h1);
        check("fe_next_data",  32'(data_o),  32'h5A);
        pop_one();

        // Nine frames into an eight-entry FIFO.
        for (int i = 1; i <= 9; i++) send_byte(8'(i), 1'b1);
        tick(5);
        @(negedge clk);
        check("ov_level", 32'(level_o),    32'h8);
        check("ov_flag",  32'(overflow_o), 32'h1);
        check("ov_head",  32'(data_o),     32'h1);
        tick(1);
        clear_i = 1'b1;
        tick(1);
        clear_i = 1'b0;
        @(negedge clk);
        check("ov_cleared", 32'(overflow_o), 32'h0);
        check("ov_lvl_kept", 32'(level_o),   32'h8);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            check("ov_drain", 32'(data_o), 32'(i));
            pop_one();
        end
        @(negedge clk);
        check("ov_empty", 32'(valid_o), 32'h0);

        // Reset mid-frame with a byte already queued.
        send_byte(8'h77, 1'b1);
        tick(2);
        rxd = 1'b0;
        tick(CPB);
        rxd = 1'b1;
        tick(4 * CPB + 5);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(60);
        @(negedge clk);
        check("mr_level", 32'(level_o),     32'h0);
        check("mr_valid", 32'(valid_o),     32'h0);
        check("mr_data",  32'(data_o),      32'h0);
        check("mr_ferr",  32'(frame_err_o), 32'h0);
        check("mr_ovf",   32'(overflow_o),  32'h0);
        check("mr_idle",  32'(dut.r_state), 32'(IDLE));
        send_byte(8'h3C, 1'b1);
        tick(5);
        @(negedge clk);
        check("mr_next_data",  32'(data_o),  32'h3C);
        check("mr_next_level", 32'(level_o), 32'h1);
        pop_one();

        // Back-to-back frames with no idle gap, consumer always ready.
        tick(5);
        fe0 = fe_total;
        n0  = popq.size();
        ready_i = 1'b1;
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        send_byte(8'h55, 1'b1);
        tick(5);
        ready_i = 1'b0;
        @(negedge clk);
        check("bb_count", 32'(popq.size() - n0), 32'h3);
        if (popq.size() >= n0 + 3) begin
            check("bb_b0", 32'(popq[n0]),     32'h00);
            check("bb_b1", 32'(popq[n0 + 1]), 32'hFF);
            check("bb_b2", 32'(popq[n0 + 2]), 32'h55);
        end
        check("bb_ferr",  fe_total - fe0,   32'h0);
        check("bb_ovf",   32'(overflow_o),  32'h0);
        check("bb_level", 32'(level_o),     32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
